// File: rtl/audio_voice_mixer_if.sv
// Bus interface for audio_voice_mixer: frame request / backpressure handshake,
// the per-voice sample and control buses, and the Audio_Controller write side.
// The master modport is the driver of voices and requests (synth top level);
// the slave modport is the mixer itself.
interface audio_voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int IN_W       = 7,
  parameter int GAIN_W     = 4,
  parameter int OUT_W      = 32
);
  logic                         sample_req;
  logic                         audio_out_allowed;
  logic [NUM_VOICES*IN_W-1:0]   voice_samples;
  logic [NUM_VOICES*GAIN_W-1:0] voice_gain;
  logic [NUM_VOICES-1:0]        voice_enable;
  logic [2*NUM_VOICES-1:0]      voice_pan;
  logic [2:0]                   master_shift;
  logic [OUT_W-1:0]             left_channel_audio_out;
  logic [OUT_W-1:0]             right_channel_audio_out;
  logic                         write_audio_out;
  logic                         busy;
  logic                         clip;

  modport master (
    output sample_req, audio_out_allowed, voice_samples, voice_gain,
           voice_enable, voice_pan, master_shift,
    input  left_channel_audio_out, right_channel_audio_out,
           write_audio_out, busy, clip
  );

  modport slave (
    input  sample_req, audio_out_allowed, voice_samples, voice_gain,
           voice_enable, voice_pan, master_shift,
    output left_channel_audio_out, right_channel_audio_out,
           write_audio_out, busy, clip
  );
endinterface

// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: mixes NUM_VOICES unsigned offset-binary voices into one
// signed, saturated, left-justified stereo sample per audio frame.
// One voice is multiplied and accumulated per cycle; the sum is then shifted,
// saturated and written to the Audio_Controller when its FIFO has space.
// Optional feature macro: STEREO_PAN_EN -- per-voice panning with separate
// left/right accumulators. Without it the mix is mono and both channels carry
// the same word.
module audio_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int IN_W       = 7,
  parameter int GAIN_W     = 4,
  parameter int MIX_W      = 12,
  parameter int OUT_W      = 32
) (
  input logic CLOCK_50,
  input logic resetn,
  audio_voice_mixer_if.slave bus
);

  // Signed product width and accumulator width (product plus growth for the sum).
  localparam int SUM_W  = IN_W + 1 + GAIN_W;
  localparam int ACC_W  = SUM_W + $clog2(NUM_VOICES);
  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  // Comparison width covers both the accumulator and the mix range.
  localparam int CMP_W  = ((ACC_W > MIX_W) ? ACC_W : MIX_W) + 1;

  localparam logic [IN_W:0]           OFFSET  = (IN_W + 1)'(2 ** (IN_W - 1));
  localparam logic signed [CMP_W-1:0] MIX_MAX = CMP_W'(2 ** (MIX_W - 1) - 1);
  localparam logic signed [CMP_W-1:0] MIX_MIN = ~MIX_MAX;
  localparam logic [VIDX_W-1:0]       LAST_V  = VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} state_t;

  typedef struct packed {
    logic [MIX_W-1:0] mix;
    logic             sat;
  } sat_t;

  // Arithmetic shift then clamp to the signed MIX_W range.
  function automatic sat_t saturate(input logic signed [ACC_W-1:0] acc,
                                    input logic [2:0] shift);
    logic signed [ACC_W-1:0] m;
    logic signed [CMP_W-1:0] w;
    sat_t r;
    m = acc >>> shift;
    w = CMP_W'(m);
    if (w > MIX_MAX) begin
      r.mix = MIX_MAX[MIX_W-1:0];
      r.sat = 1'b1;
    end else if (w < MIX_MIN) begin
      r.mix = MIX_MIN[MIX_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.mix = w[MIX_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] justify(input logic [MIX_W-1:0] mix);
    return {mix, {(OUT_W - MIX_W){1'b0}}};
  endfunction

  state_t                       state;
  logic [VIDX_W-1:0]            vidx;
  logic [NUM_VOICES*IN_W-1:0]   samp_q;
  logic [NUM_VOICES*GAIN_W-1:0] gain_q;
  logic [NUM_VOICES-1:0]        en_q;
  logic [2:0]                   shift_q;
  logic signed [ACC_W-1:0]      acc_l;
  logic [MIX_W-1:0]             mix_l_q;
  logic                         clip_pend;
  logic [OUT_W-1:0]             left_q;
  logic                         write_q;
  logic                         busy_q;
  logic                         clip_q;

  logic [IN_W-1:0]              cur_sample;
  logic [GAIN_W-1:0]            cur_gain;
  logic                         cur_en;
  logic signed [IN_W:0]         centered;
  logic signed [SUM_W-1:0]      c_ext;
  logic signed [SUM_W-1:0]      g_ext;
  logic signed [SUM_W-1:0]      product;
  logic signed [ACC_W-1:0]      term_l;
  sat_t                         sat_l;

`ifdef STEREO_PAN_EN
  logic [2*NUM_VOICES-1:0]      pan_q;
  logic [1:0]                   cur_pan;
  logic signed [ACC_W-1:0]      acc_r;
  logic signed [ACC_W-1:0]      term_r;
  logic [MIX_W-1:0]             mix_r_q;
  logic [OUT_W-1:0]             right_q;
  sat_t                         sat_r;
`else
  // Pan controls have no meaning in the mono build.
  logic unused_pan;
  assign unused_pan = ^bus.voice_pan;
`endif

  // Signed contribution of the voice selected by vidx.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    cur_sample = samp_q[int'(vidx)*IN_W +: IN_W];
    cur_gain   = gain_q[int'(vidx)*GAIN_W +: GAIN_W];
    cur_en     = en_q[vidx];
    centered   = {1'b0, cur_sample} - OFFSET;
    c_ext      = SUM_W'(centered);
    g_ext      = SUM_W'({1'b0, cur_gain});
    product    = c_ext * g_ext;
`ifdef STEREO_PAN_EN
    cur_pan    = pan_q[int'(vidx)*2 +: 2];
    term_l     = (cur_en && cur_pan != 2'b10) ? ACC_W'(product) : '0;
    term_r     = (cur_en && cur_pan != 2'b01) ? ACC_W'(product) : '0;
`else
    term_l     = cur_en ? ACC_W'(product) : '0;
`endif
  end

  // Shifted and saturated view of the finished accumulator(s).
  always_comb begin
    sat_l = saturate(acc_l, shift_q);
`ifdef STEREO_PAN_EN
    sat_r = saturate(acc_r, shift_q);
`endif
  end

  // Frame sequencer: capture, accumulate, scale, write.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the snapshot registers are reset too, so an aborted frame leaves no residue.
      state     <= IDLE;
      vidx      <= '0;
      samp_q    <= '0;
      gain_q    <= '0;
      en_q      <= '0;
      shift_q   <= '0;
      acc_l     <= '0;
      mix_l_q   <= '0;
      clip_pend <= 1'b0;
      left_q    <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      clip_q    <= 1'b0;
`ifdef STEREO_PAN_EN
      pan_q     <= '0;
      acc_r     <= '0;
      mix_r_q   <= '0;
      right_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here; the defaults below make the strobe and clip one-cycle pulses.
      write_q <= 1'b0;
      clip_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_req && bus.audio_out_allowed) begin
            samp_q  <= bus.voice_samples;
            gain_q  <= bus.voice_gain;
            en_q    <= bus.voice_enable;
            shift_q <= bus.master_shift;
            acc_l   <= '0;
            vidx    <= '0;
            busy_q  <= 1'b1;
            state   <= ACCUM;
`ifdef STEREO_PAN_EN
            pan_q   <= bus.voice_pan;
            acc_r   <= '0;
`endif
          end
        end
        ACCUM: begin
          acc_l <= acc_l + term_l;
`ifdef STEREO_PAN_EN
          acc_r <= acc_r + term_r;
`endif
          if (vidx == LAST_V) begin
            state <= SCALE;
          end else begin
            vidx <= vidx + 1'b1;
          end
        end
        SCALE: begin
          mix_l_q <= sat_l.mix;
`ifdef STEREO_PAN_EN
          mix_r_q   <= sat_r.mix;
          clip_pend <= sat_l.sat | sat_r.sat;
`else
          clip_pend <= sat_l.sat;
`endif
          state <= WRITE;
        end
        WRITE: begin
          if (bus.audio_out_allowed) begin
            left_q  <= justify(mix_l_q);
`ifdef STEREO_PAN_EN
            right_q <= justify(mix_r_q);
`endif
            write_q <= 1'b1;
            clip_q  <= clip_pend;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.left_channel_audio_out  = left_q;
`ifdef STEREO_PAN_EN
  assign bus.right_channel_audio_out = right_q;
`else
  assign bus.right_channel_audio_out = left_q;
`endif
  assign bus.write_audio_out = write_q;
  assign bus.busy            = busy_q;
  assign bus.clip            = clip_q;

endmodule
